// File: rtl/hydration_scheduler.sv
// Hydration reminder controller: interval/snooze FSM, drink detection and a per-day drink counter.
// Optional escalation flag on the final alert is enabled by defining HYDRATION_ESCALATE_EN.
module hydration_scheduler #(
  parameter int unsigned INTERVAL_MIN = 60,
  parameter int unsigned SNOOZE_MIN   = 10,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter logic [7:0]  WAKE_HOUR    = 8'h07,
  parameter logic [7:0]  SLEEP_HOUR   = 8'h22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       min_tick,
  input  logic [3:0] hMSD,
  input  logic [3:0] hLSD,
  input  logic [3:0] water_level,
  input  logic       ack,
  output logic       remind,
  output logic       missed,
  output logic [7:0] drink_count,
  output logic [1:0] state_o,
  output logic       urgent
);

  typedef enum logic [1:0] {
    S_SLEEP  = 2'd0,
    S_WAIT   = 2'd1,
    S_ALERT  = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

`ifdef HYDRATION_ESCALATE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  localparam logic [7:0] INT_LAST = 8'(INTERVAL_MIN - 1);
  localparam logic [7:0] SNZ_LAST = 8'(SNOOZE_MIN - 1);
  localparam logic [3:0] ACK_LAST = 4'(MAX_SNOOZE - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] snz_q;
  logic [3:0] prev_q;
  logic       remind_q;
  logic       missed_q;
  logic [7:0] drink_q;
  logic       urgent_q;

  logic [7:0] hour;
  logic       in_win;
  logic       drink;
  logic       final_alert;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign hour        = {hMSD, hLSD};
  assign in_win      = (hMSD <= 4'd9) && (hLSD <= 4'd9) &&
                       (hour >= WAKE_HOUR) && (hour < SLEEP_HOUR);
  assign drink       = (water_level < prev_q);
  assign final_alert = ESC_EN && (snz_q == ACK_LAST);

  // remind/urgent default low each cycle; they are re-asserted only when entering or staying in ALERT
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_SLEEP;
      cnt_q    <= 8'd0;
      snz_q    <= 4'd0;
      prev_q   <= 4'h0;
      remind_q <= 1'b0;
      missed_q <= 1'b0;
      drink_q  <= 8'd0;
      urgent_q <= 1'b0;
    end else begin
      prev_q   <= water_level;
      missed_q <= 1'b0;
      remind_q <= 1'b0;
      urgent_q <= 1'b0;
      if (!in_win) begin
        state_q <= S_SLEEP;
        cnt_q   <= 8'd0;
        snz_q   <= 4'd0;
      end else begin
        case (state_q)
          S_SLEEP: begin
            state_q <= S_WAIT;
            cnt_q   <= 8'd0;
            snz_q   <= 4'd0;
            drink_q <= 8'd0;
          end
          S_WAIT: begin
            if (drink) begin
              cnt_q   <= 8'd0;
              drink_q <= sat_inc(drink_q);
            end else if (min_tick) begin
              if (cnt_q == INT_LAST) begin
                state_q  <= S_ALERT;
                cnt_q    <= 8'd0;
                remind_q <= 1'b1;
                urgent_q <= final_alert;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          S_ALERT: begin
            if (drink) begin
              state_q <= S_WAIT;
              cnt_q   <= 8'd0;
              snz_q   <= 4'd0;
              drink_q <= sat_inc(drink_q);
            end else if (ack) begin
              cnt_q <= 8'd0;
              if (snz_q == ACK_LAST) begin
                state_q  <= S_WAIT;
                snz_q    <= 4'd0;
                missed_q <= 1'b1;
              end else begin
                state_q <= S_SNOOZE;
                snz_q   <= snz_q + 4'd1;
              end
            end else begin
              remind_q <= 1'b1;
              urgent_q <= final_alert;
            end
          end
          S_SNOOZE: begin
            if (drink) begin
              state_q <= S_WAIT;
              cnt_q   <= 8'd0;
              snz_q   <= 4'd0;
              drink_q <= sat_inc(drink_q);
            end else if (min_tick) begin
              if (cnt_q == SNZ_LAST) begin
                state_q  <= S_ALERT;
                cnt_q    <= 8'd0;
                remind_q <= 1'b1;
                urgent_q <= final_alert;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= S_SLEEP;
        endcase
      end
    end
  end

  assign remind      = remind_q;
  assign missed      = missed_q;
  assign drink_count = drink_q;
  assign state_o     = state_q;
  assign urgent      = urgent_q;

endmodule

// File: tb/tb_hydration_scheduler.sv
// Scoreboard bench for hydration_scheduler with INTERVAL_MIN=3, SNOOZE_MIN=2, MAX_SNOOZE=2.
// Define HYDRATION_ESCALATE_EN for both files to check the urgent flag.
module tb_hydration_scheduler;

`ifdef HYDRATION_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       min_tick;
  logic [3:0] hMSD;
  logic [3:0] hLSD;
  logic [3:0] water_level;
  logic       ack;
  logic       remind;
  logic       missed;
  logic [7:0] drink_count;
  logic [1:0] state_o;
  logic       urgent;

  typedef struct packed {
    logic [1:0] st;
    logic       rem;
    logic       mis;
    logic [7:0] dc;
    logic       urg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  hydration_scheduler #(
    .INTERVAL_MIN(3),
    .SNOOZE_MIN  (2),
    .MAX_SNOOZE  (2),
    .WAKE_HOUR   (8'h07),
    .SLEEP_HOUR  (8'h22)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .min_tick   (min_tick),
    .hMSD       (hMSD),
    .hLSD       (hLSD),
    .water_level(water_level),
    .ack        (ack),
    .remind     (remind),
    .missed     (missed),
    .drink_count(drink_count),
    .state_o    (state_o),
    .urgent     (urgent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input string nm, input bit tk, input bit ak, input bit rs,
                      input logic [7:0] hr, input logic [3:0] lv,
                      input logic [1:0] st, input bit rem, input bit mis,
                      input int dc, input bit urg);
    exp_t e;
    @(negedge clk);
    min_tick    = tk;
    ack         = ak;
    reset       = rs;
    hMSD        = hr[7:4];
    hLSD        = hr[3:0];
    water_level = lv;
    e.st  = st;
    e.rem = rem;
    e.mis = mis;
    e.dc  = 8'(dc);
    e.urg = ESC & urg;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Monitor: every cycle with a pending expectation is compared against the registered outputs.
  initial begin
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got.st  = state_o;
        got.rem = remind;
        got.mis = missed;
        got.dc  = drink_count;
        got.urg = urgent;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s: got st=%0d remind=%0b missed=%0b dc=%0d urgent=%0b, required st=%0d remind=%0b missed=%0b dc=%0d urgent=%0b",
                   nm, got.st, got.rem, got.mis, got.dc, got.urg,
                   e.st, e.rem, e.mis, e.dc, e.urg);
        end
      end
    end
  end

  initial begin
    int d;
    reset = 1'b0; min_tick = 1'b0; ack = 1'b0;
    hMSD = 4'h1; hLSD = 4'h0; water_level = 4'hF;

    //    name          tk ak rs hour   lvl    st rem mis dc urg
    step("reset0",      0, 0, 0, 8'h10, 4'hF, 0, 0, 0, 0, 0);
    step("reset1",      0, 0, 0, 8'h10, 4'hF, 0, 0, 0, 0, 0);
    step("release",     0, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);
    step("wait_t1",     1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);
    step("wait_t2",     1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);
    step("alert1",      1, 0, 1, 8'h10, 4'hF, 2, 1, 0, 0, 0);
    step("alert_tick",  1, 0, 1, 8'h10, 4'hF, 2, 1, 0, 0, 0);
    step("snooze",      0, 1, 1, 8'h10, 4'hF, 3, 0, 0, 0, 0);
    step("snooze_t1",   1, 0, 1, 8'h10, 4'hF, 3, 0, 0, 0, 0);
    step("realert",     1, 0, 1, 8'h10, 4'hF, 2, 1, 0, 0, 1);
    step("alert2_hold", 0, 0, 1, 8'h10, 4'hF, 2, 1, 0, 0, 1);
    step("missed",      0, 1, 1, 8'h10, 4'hF, 1, 0, 1, 0, 0);
    step("missed_clr",  0, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);

    step("dr_t1",       1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);
    step("dr_t2",       1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 0, 0);
    step("drink",       0, 0, 1, 8'h10, 4'hC, 1, 0, 0, 1, 0);
    step("refill",      0, 0, 1, 8'h10, 4'hF, 1, 0, 0, 1, 0);
    step("post_t1",     1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 1, 0);
    step("post_t2",     1, 0, 1, 8'h10, 4'hF, 1, 0, 0, 1, 0);
    step("post_alert",  1, 0, 1, 8'h10, 4'hF, 2, 1, 0, 1, 0);

    step("drink_ack",   0, 1, 1, 8'h10, 4'hC, 1, 0, 0, 2, 0);
    step("da_t1",       1, 0, 1, 8'h10, 4'hC, 1, 0, 0, 2, 0);
    step("da_t2",       1, 0, 1, 8'h10, 4'hC, 1, 0, 0, 2, 0);
    step("da_alert",    1, 0, 1, 8'h10, 4'hC, 2, 1, 0, 2, 0);
    step("snz_cleared", 0, 1, 1, 8'h10, 4'hC, 3, 0, 0, 2, 0);
    step("da_snz_t1",   1, 0, 1, 8'h10, 4'hC, 3, 0, 0, 2, 0);
    step("da_realert",  1, 0, 1, 8'h10, 4'hC, 2, 1, 0, 2, 1);

    step("hour_21",     0, 0, 1, 8'h21, 4'hC, 2, 1, 0, 2, 1);
    step("hour_22",     0, 0, 1, 8'h22, 4'hC, 0, 0, 0, 2, 0);
    step("hour_1A",     0, 0, 1, 8'h1A, 4'hC, 0, 0, 0, 2, 0);
    step("hour_07",     0, 0, 1, 8'h07, 4'hC, 1, 0, 0, 0, 0);
    step("hour_0A",     0, 0, 1, 8'h0A, 4'hC, 0, 0, 0, 0, 0);
    step("hour_10",     0, 0, 1, 8'h10, 4'hC, 1, 0, 0, 0, 0);

    step("ra_t1",       1, 0, 1, 8'h10, 4'hC, 1, 0, 0, 0, 0);
    step("ra_t2",       1, 0, 1, 8'h10, 4'hC, 1, 0, 0, 0, 0);
    step("ra_alert",    1, 0, 1, 8'h10, 4'hC, 2, 1, 0, 0, 0);
    step("reset_alert", 0, 1, 0, 8'h10, 4'hC, 0, 0, 0, 0, 0);
    step("ra_release",  0, 0, 1, 8'h10, 4'hC, 1, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) begin
      d = (i + 1 > 255) ? 255 : i + 1;
      step("sat_drink",  0, 0, 1, 8'h10, 4'h3, 1, 0, 0, d, 0);
      step("sat_refill", 0, 0, 1, 8'h10, 4'hC, 1, 0, 0, d, 0);
    end
    step("final_idle",  0, 0, 1, 8'h10, 4'hC, 1, 0, 0, 255, 0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hydration_scheduler.md
Name: hydration_scheduler

Overview:
Minute-driven controller that decides when the hydration reminder fires.
- Consumes the BCD hour ({hMSD,hLSD}), a one-cycle-per-minute tick, the 4-bit bottle water level and a user acknowledge.
- Runs an interval/snooze state machine and drives the remind output for the display/buzzer path.
- Keeps a per-day drink counter.
- Sits between the real-time-clock divider and the reminder indicator.

Parameters:
INTERVAL_MIN, 60, minutes without a drink before a reminder fires (1..255)
SNOOZE_MIN, 10, minutes between a snooze acknowledge and the re-alert (1..255)
MAX_SNOOZE, 3, acknowledges allowed per reminder before it is logged as missed (1..15)
WAKE_HOUR, 8'h07, BCD hour at which the active window opens (inclusive)
SLEEP_HOUR, 8'h22, BCD hour at which the active window closes (exclusive)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
min_tick  in  1  one-cycle pulse per elapsed minute
hMSD  in  4  BCD hour tens digit
hLSD  in  4  BCD hour units digit
water_level  in  4  bottle level, 0 = empty, 15 = full
ack  in  1  one-cycle user acknowledge (snooze) pulse
remind  out  1  reminder active
missed  out  1  one-cycle pulse when a reminder exhausts its snoozes
drink_count  out  8  drinks detected since the window opened, saturating at 255
state_o  out  2  current state: 0 SLEEP, 1 WAIT, 2 ALERT, 3 SNOOZE
urgent  out  1  escalation flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=SLEEP; minute counter=0; snooze_cnt=0; prev_level=4'h0.
  - remind=0, missed=0, drink_count=0, urgent=0.
- Window: in_win = both digits <=9 AND WAKE_HOUR <= {hMSD,hLSD} < SLEEP_HOUR, compared as 8-bit unsigned. An invalid BCD digit means outside the window.
- Drink: drink = (water_level < prev_level). prev_level <= water_level every cycle. A level increase (refill) is not a drink. The prev_level reset value 0 guarantees no false drink after reset.
- Each drink in WAIT, ALERT or SNOOZE increments drink_count (saturating at 255).
- Event priority in every state: !in_win > drink > ack > min_tick. Only the highest-priority event acts in a given cycle.
- States:
  - SLEEP: counters held at 0. When in_win is true: go to WAIT, clear drink_count and snooze_cnt.
  - WAIT: each min_tick increments the counter. A min_tick with counter==INTERVAL_MIN-1 goes to ALERT and clears the counter. A drink clears the counter and stays in WAIT. ack is ignored.
  - ALERT: drink -> WAIT, counter=0, snooze_cnt=0. On ack:
    - if snooze_cnt==MAX_SNOOZE-1: pulse missed for one cycle, go to WAIT, counter=0, snooze_cnt=0;
    - otherwise: snooze_cnt++, go to SNOOZE, counter=0.
    - min_tick is ignored.
  - SNOOZE: each min_tick increments the counter. A min_tick with counter==SNOOZE_MIN-1 goes to ALERT. drink -> WAIT, snooze_cnt=0. ack is ignored.
  - Any state with !in_win: go to SLEEP next cycle and clear counters. drink_count holds until the next window opens.
- Outputs:
  - remind = registered (state==ALERT). It rises the cycle after the triggering min_tick and falls the cycle after the ack or drink.
  - state_o reflects the registered state.
- Latency: one clock from any input event to the state/output change.
- Reset mid-ALERT: remind drops the cycle after reset is sampled low. No missed pulse is generated.
- Simultaneous drink and ack in ALERT: drink wins. Go to WAIT, no snooze recorded.

Optional Feature:
Macro HYDRATION_ESCALATE_EN.
- Defined: urgent = registered (state==ALERT && snooze_cnt==MAX_SNOOZE-1), i.e. the final alert before missed. urgent clears together with remind.
- Undefined: urgent is tied to 0 and no extra logic is generated. All other behaviour is identical.

Test Plan:
All scenarios use INTERVAL_MIN=3, SNOOZE_MIN=2, MAX_SNOOZE=2, hour=8'h10, water_level held at 4'hF unless stated.
- Reset low 2 cycles, then release with hour 8'h10 -> state SLEEP then WAIT next cycle. remind=0, drink_count=0.
- 3 min_ticks in WAIT -> remind=1 the cycle after the 3rd tick, state_o=2.
- In ALERT: ack -> SNOOZE, remind=0. 2 min_ticks -> ALERT again. ack -> missed pulses 1 cycle, state WAIT. With HYDRATION_ESCALATE_EN, urgent=1 during the second ALERT only.
- Two min_ticks, then water_level 15 -> 12 -> counter cleared, drink_count=1. 3 more ticks are needed before remind. A level change 12 -> 15 does not change drink_count.
- In ALERT, drink and ack in the same cycle -> WAIT, missed=0, snooze_cnt=0, drink_count+1.
- Hour changes 8'h21 -> 8'h22 while in ALERT -> SLEEP, remind=0 next cycle. Hour 8'h1A (invalid BCD) -> SLEEP. Hour back to 8'h07 -> WAIT, drink_count cleared.
